cxl_responder: RTL
==================

CXL_RESPONDER -- requirements
Module: cxl_responder

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 64, address width; DATA_W, default 512, line width; ID_W, default 16, transaction ID width; LINES, default 64, backing-store depth (power of 2); RD_LAT, default 4, read latency in cycles (≥1).
REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- arid_i  in  ID_W  read ID.
- araddr_i  in  ADDR_W  read address.
- arvalid_i  in  1  read address valid.
- arready_o  out  1  read address ready.
- rid_o  out  ID_W  read response ID.
- rdata_o  out  DATA_W  read data.
- rvalid_o  out  1  read response valid.
- rready_i  in  1  read response ready.
- awid_i  in  ID_W  write ID.
- awaddr_i  in  ADDR_W  write address.
- awvalid_i  in  1  write address valid.
- awready_o  out  1  write address ready.
- wid_i  in  ID_W  write data ID (ignored for matching).
- wdata_i  in  DATA_W  write data.
- wvalid_i  in  1  write data valid.
- wready_o  out  1  write data ready.
- bid_o  out  ID_W  write response ID (= captured awid).
- bvalid_o  out  1  write response valid.
- bready_i  in  1  write response ready.

Function
REQ-003 Line index SHALL be addr[6 +: log2(LINES)]; bits [5:0] and upper bits SHALL be ignored.
REQ-004 The block SHALL keep one valid bit per line; reads of a line whose valid bit is 0 SHALL return all-zero data.
REQ-005 Read FSM states SHALL be R_IDLE, R_WAIT, R_RESP; arready_o SHALL be 1 only in R_IDLE.
REQ-006 On arvalid_i&&arready_o the block SHALL capture arid/index, load a counter with RD_LAT-1, and enter R_WAIT.
REQ-007 In R_WAIT the counter SHALL decrement each cycle; at 0 the block SHALL sample the line into rdata_o and enter R_RESP, so rvalid_o rises exactly RD_LAT cycles after the AR handshake edge.
REQ-008 In R_RESP rvalid_o SHALL hold 1 and rid_o/rdata_o stable until rready_i; on the handshake the FSM SHALL return to R_IDLE, with the next AR accepted no earlier than the following cycle.
REQ-009 Write FSM states SHALL be W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP; awready_o SHALL be 1 in W_IDLE and W_HAVE_W, and wready_o SHALL be 1 in W_IDLE and W_HAVE_AW.
REQ-010 AW and W arriving in the same cycle in W_IDLE SHALL both be accepted, and the block SHALL go directly to W_RESP.
REQ-011 On completion of the AW and W pair, the line SHALL be written, its valid bit set, and bid_o set to the captured awid, with bvalid_o=1 in the next cycle (W_RESP).
REQ-012 bvalid_o SHALL hold until bready_i; on the handshake the FSM SHALL return to W_IDLE.
REQ-013 Read and write FSMs SHALL run independently; if the line write and the read sample (REQ-007) hit the same line in the same cycle, the read SHALL return the pre-write data.
REQ-014 Only one read and one write SHALL be outstanding at a time; there is no reordering.

Reset
REQ-015 While rst_n=0 (asynchronous assertion): both FSMs SHALL go to IDLE, all valid bits SHALL clear, and arready_o=1, awready_o=1, wready_o=1, rvalid_o=0, bvalid_o=0, rid_o=0, rdata_o=0, bid_o=0; line data SHALL not be reset.
REQ-016 Reset mid-transaction SHALL drop the in-flight read and write without producing any response after release.

Structure
REQ-017 Package cxl_pkg SHALL hold the ADDR_W, DATA_W, and ID_W defaults and the read and write FSM state enums.
REQ-018 The line array plus valid bits SHALL be one sub-module, cxl_line_mem, with a 1W/1R port, a combinational read, and a synchronous write.

Verification
REQ-019 Unwritten read: AR addr 0x40, id 3 -> rvalid exactly 4 cycles later, rid=3, rdata=0.
REQ-020 Same-cycle AW and W: addr 0x0000000f00000040, id 5, data 0xddd…d -> bvalid next cycle with bid=5; a later read of 0x40 returns 0xddd…d.
REQ-021 W before AW by 3 cycles: wready drops after W, AW accepted later -> exactly one bvalid; data committed.
REQ-022 Backpressure: hold rready=0 and bready=0 for 5 cycles -> rvalid/rdata and bvalid/bid stable; arready=0 and awready=0 throughout.
REQ-023 Collision: read of line 1 reaches its sample cycle in the same cycle a write to line 1 commits -> the read returns old data; a subsequent read returns new data.
REQ-024 Reset asserted while in R_WAIT and W_HAVE_AW -> no rvalid or bvalid afterwards; reads of previously written lines return 0.

Source files
------------

// File: rtl/cxl_pkg.sv
// -----------------------------------------------------------------------------
// cxl_pkg
// Shared definitions for the CXL memory responder:
//   - default address / data / ID widths
//   - byte offset of the line index inside an address (64-byte lines)
//   - read and write FSM state encodings
//   - helper that sizes the read-latency counter
// -----------------------------------------------------------------------------
package cxl_pkg;

    localparam int ADDR_W_DEF  = 64;
    localparam int DATA_W_DEF  = 512;
    localparam int ID_W_DEF    = 16;
    localparam int LINE_OFFSET = 6;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_state_e;

    // A latency of 1 still needs a 1-bit counter (it is simply loaded with 0).
    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/cxl_line_mem.sv
// -----------------------------------------------------------------------------
// cxl_line_mem
// Backing store of LINES cache lines plus one valid bit per line.
// Ports:
//   clk, rst_n        clock / async active-low reset (clears valid bits only)
//   we_i, widx_i,     synchronous write port; a write also sets the line's
//   wdata_i           valid bit
//   ridx_i, rdata_o   combinational read port; an invalid line reads as zero
// -----------------------------------------------------------------------------
module cxl_line_mem
    import cxl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LINES  = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we_i,
    input  logic [$clog2(LINES)-1:0] widx_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [$clog2(LINES)-1:0] ridx_i,
    output logic [DATA_W-1:0]        rdata_o
);

    logic [DATA_W-1:0] mem_q [LINES];
    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  valid_d;

    always_comb begin
        valid_d = valid_q;
        if (we_i) begin
            valid_d[widx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Line contents are deliberately not reset; the valid bits mask them.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    // Combinational read: a write in the same cycle is seen only afterwards,
    // so a colliding read sample returns the pre-write contents.
    assign rdata_o = valid_q[ridx_i] ? mem_q[ridx_i] : '0;

endmodule

// File: rtl/cxl_responder.sv
// -----------------------------------------------------------------------------
// cxl_responder
// Single-outstanding AXI-like memory responder over a line store.
// Ports:
//   clk, rst_n                     clock / async active-low reset
//   AR: arid_i araddr_i arvalid_i arready_o
//   R : rid_o rdata_o rvalid_o rready_i       (fixed RD_LAT-cycle latency)
//   AW: awid_i awaddr_i awvalid_i awready_o
//   W : wid_i wdata_i wvalid_i wready_o       (wid_i not used for matching)
//   B : bid_o bvalid_o bready_i
// Read and write paths are independent FSMs sharing the line memory.
// -----------------------------------------------------------------------------
module cxl_responder
    import cxl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ID_W   = ID_W_DEF,
    parameter int LINES  = 64,
    parameter int RD_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ID_W-1:0]   arid_i,
    input  logic [ADDR_W-1:0] araddr_i,
    input  logic              arvalid_i,
    output logic              arready_o,
    output logic [ID_W-1:0]   rid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o,
    input  logic              rready_i,
    input  logic [ID_W-1:0]   awid_i,
    input  logic [ADDR_W-1:0] awaddr_i,
    input  logic              awvalid_i,
    output logic              awready_o,
    input  logic [ID_W-1:0]   wid_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    output logic [ID_W-1:0]   bid_o,
    output logic              bvalid_o,
    input  logic              bready_i
);

    localparam int IDX_W = $clog2(LINES);
    localparam int CNT_W = cnt_width(RD_LAT);

    // Only the line-index bits of the addresses matter; the rest, and the
    // W-channel ID, are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{wid_i, araddr_i, awaddr_i};

    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // ---------------- read path ----------------
    rd_state_e         rd_state_q, rd_state_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [IDX_W-1:0]  ridx_q, ridx_d;
    logic [CNT_W-1:0]  rcnt_q, rcnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_comb begin
        rd_state_d = rd_state_q;
        rid_d      = rid_q;
        ridx_d     = ridx_q;
        rcnt_d     = rcnt_q;
        rdata_d    = rdata_q;
        case (rd_state_q)
            R_IDLE: begin
                if (arvalid_i) begin
                    rid_d      = arid_i;
                    ridx_d     = araddr_i[LINE_OFFSET +: IDX_W];
                    rcnt_d     = CNT_W'(RD_LAT - 1);
                    rd_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                // Counter hits zero on the RD_LAT-th edge after the handshake.
                if (rcnt_q == '0) begin
                    rdata_d    = mem_rdata;
                    rd_state_d = R_RESP;
                end else begin
                    rcnt_d = rcnt_q - 1'b1;
                end
            end
            R_RESP: begin
                if (rready_i) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // ---------------- write path ----------------
    wr_state_e         wr_state_q, wr_state_d;
    logic [ID_W-1:0]   awid_q, awid_d;
    logic [IDX_W-1:0]  widx_q, widx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ID_W-1:0]   bid_q, bid_d;
    logic              aw_hs;
    logic              w_hs;

    assign awready_o = (wr_state_q == W_IDLE) || (wr_state_q == W_HAVE_W);
    assign wready_o  = (wr_state_q == W_IDLE) || (wr_state_q == W_HAVE_AW);
    assign aw_hs     = awvalid_i && awready_o;
    assign w_hs      = wvalid_i && wready_o;

    always_comb begin
        wr_state_d = wr_state_q;
        awid_d     = awid_q;
        widx_d     = widx_q;
        wdata_d    = wdata_q;
        bid_d      = bid_q;
        mem_we     = 1'b0;
        mem_widx   = widx_q;
        mem_wdata  = wdata_q;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    mem_we     = 1'b1;
                    mem_widx   = awaddr_i[LINE_OFFSET +: IDX_W];
                    mem_wdata  = wdata_i;
                    bid_d      = awid_i;
                    wr_state_d = W_RESP;
                end else if (aw_hs) begin
                    awid_d     = awid_i;
                    widx_d     = awaddr_i[LINE_OFFSET +: IDX_W];
                    wr_state_d = W_HAVE_AW;
                end else if (w_hs) begin
                    wdata_d    = wdata_i;
                    wr_state_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                if (w_hs) begin
                    mem_we     = 1'b1;
                    mem_widx   = widx_q;
                    mem_wdata  = wdata_i;
                    bid_d      = awid_q;
                    wr_state_d = W_RESP;
                end
            end
            W_HAVE_W: begin
                if (aw_hs) begin
                    mem_we     = 1'b1;
                    mem_widx   = awaddr_i[LINE_OFFSET +: IDX_W];
                    mem_wdata  = wdata_q;
                    bid_d      = awid_i;
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bready_i) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= R_IDLE;
            rid_q      <= '0;
            ridx_q     <= '0;
            rcnt_q     <= '0;
            rdata_q    <= '0;
            wr_state_q <= W_IDLE;
            awid_q     <= '0;
            widx_q     <= '0;
            wdata_q    <= '0;
            bid_q      <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rid_q      <= rid_d;
            ridx_q     <= ridx_d;
            rcnt_q     <= rcnt_d;
            rdata_q    <= rdata_d;
            wr_state_q <= wr_state_d;
            awid_q     <= awid_d;
            widx_q     <= widx_d;
            wdata_q    <= wdata_d;
            bid_q      <= bid_d;
        end
    end

    assign arready_o = (rd_state_q == R_IDLE);
    assign rvalid_o  = (rd_state_q == R_RESP);
    assign rid_o     = rid_q;
    assign rdata_o   = rdata_q;
    assign bvalid_o  = (wr_state_q == W_RESP);
    assign bid_o     = bid_q;

    cxl_line_mem #(
        .DATA_W (DATA_W),
        .LINES  (LINES)
    ) u_line_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (mem_we),
        .widx_i  (mem_widx),
        .wdata_i (mem_wdata),
        .ridx_i  (ridx_q),
        .rdata_o (mem_rdata)
    );

endmodule
